// File: rtl/gdb_rsp_tx_framer_if.sv
// Signal bundle between the reply generator, the UART tx port and the ack path
// on one side and the GDB RSP transmit framer on the other.
interface gdb_rsp_tx_framer_if;
  // Payload: a byte moves when pl_valid_i && pl_ready_o are both high at a rising edge.
  // UART: tx_send_o is a one-cycle strobe that is only raised after tx_ready_i was seen high.
  logic [7:0] pl_byte_i;
  logic       pl_valid_i;
  logic       pl_ready_o;
  logic       pl_commit_i;
  logic [7:0] tx_byte_o;
  logic       tx_send_o;
  logic       tx_ready_i;
  logic [7:0] ack_byte_i;
  logic       ack_valid_i;
  logic       busy_o;
  logic       done_o;
  logic       fail_o;
  logic [2:0] dbg_state;

  modport slave (
    input  pl_byte_i, pl_valid_i, pl_commit_i, tx_ready_i, ack_byte_i, ack_valid_i,
    output pl_ready_o, tx_byte_o, tx_send_o, busy_o, done_o, fail_o, dbg_state
  );

  modport master (
    output pl_byte_i, pl_valid_i, pl_commit_i, tx_ready_i, ack_byte_i, ack_valid_i,
    input  pl_ready_o, tx_byte_o, tx_send_o, busy_o, done_o, fail_o, dbg_state
  );
endinterface

// File: rtl/gdb_rsp_tx_framer.sv
// Buffers a reply payload and sends it as a `$payload#cc` RSP packet with escaping,
// then waits for the host's +/- acknowledgement and retransmits on - or timeout.
module gdb_rsp_tx_framer #(
  parameter int DEPTH_LOG2     = 8,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  gdb_rsp_tx_framer_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RW    = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C      = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] MAX_RETRY_C  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SOF      = 3'd1,
    S_DATA     = 3'd2,
    S_HASH     = 3'd3,
    S_CK_HI    = 3'd4,
    S_CK_LO    = 3'd5,
    S_WAIT_ACK = 3'd6
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [CW-1:0] rd_ptr, rd_ptr_n;
  logic [7:0]    checksum, checksum_n;
  logic [RW-1:0] retry, retry_n;
  logic [TW-1:0] timer, timer_n;
  logic [1:0]    hold, hold_n;
  logic          esc, esc_n;
  logic          send_q, send_n;
  logic [7:0]    byte_q, byte_n;
  logic          done_q, done_n;
  logic          fail_q, fail_n;
  logic          wr_en;
  logic [7:0]    emit_b;

  logic [7:0] mem [DEPTH];

  logic       can_emit;
  logic       accept;
  logic [7:0] cur_b;
  logic       is_special;
  logic       ack_plus;
  logic       ack_minus;
  logic       timed_out;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // After each strobe, three decision edges are skipped: the strobe cycle itself
  // plus two holdoff cycles, so the UART has time to drop tx_ready_i.
  assign can_emit   = (hold == 2'd0) && bus.tx_ready_i;
  assign accept     = (state == S_IDLE) && bus.pl_valid_i && (count < DEPTH_C);
  assign cur_b      = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign is_special = (cur_b == 8'h23) || (cur_b == 8'h24) ||
                      (cur_b == 8'h7D) || (cur_b == 8'h2A);
  assign ack_plus   = bus.ack_valid_i && (bus.ack_byte_i == 8'h2B);
  assign ack_minus  = bus.ack_valid_i && (bus.ack_byte_i == 8'h2D);
  assign timed_out  = (timer == TIMEOUT_LAST);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[count[DEPTH_LOG2-1:0]] <= bus.pl_byte_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      checksum <= 8'h00;
      retry    <= '0;
      timer    <= '0;
      hold     <= 2'd0;
      esc      <= 1'b0;
      send_q   <= 1'b0;
      byte_q   <= 8'h00;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      rd_ptr   <= rd_ptr_n;
      checksum <= checksum_n;
      retry    <= retry_n;
      timer    <= timer_n;
      hold     <= hold_n;
      esc      <= esc_n;
      send_q   <= send_n;
      byte_q   <= byte_n;
      done_q   <= done_n;
      fail_q   <= fail_n;
    end
  end

  always_comb begin
    state_n    = state;
    count_n    = count;
    rd_ptr_n   = rd_ptr;
    checksum_n = checksum;
    retry_n    = retry;
    esc_n      = esc;
    hold_n     = (hold != 2'd0) ? hold - 2'd1 : 2'd0;
    timer_n    = (state == S_WAIT_ACK) ? timer + TW'(1) : '0;
    send_n     = 1'b0;
    byte_n     = byte_q;
    done_n     = 1'b0;
    fail_n     = 1'b0;
    wr_en      = 1'b0;
    emit_b     = 8'h00;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          wr_en   = 1'b1;
          count_n = count + CW'(1);
          if (count == DEPTH_C - CW'(1)) state_n = S_SOF;
        end
        if (bus.pl_commit_i) state_n = S_SOF;
      end
      S_SOF: begin
        if (can_emit) begin
          send_n     = 1'b1;
          byte_n     = 8'h24;
          hold_n     = 2'd3;
          checksum_n = 8'h00;
          rd_ptr_n   = '0;
          esc_n      = 1'b0;
          state_n    = S_DATA;
        end
      end
      S_DATA: begin
        if (rd_ptr == count) begin
          state_n = S_HASH;
        end else if (can_emit) begin
          // Escaped bytes go out as 0x7D then byte^0x20; both count toward the checksum.
          if (esc) begin
            emit_b   = cur_b ^ 8'h20;
            esc_n    = 1'b0;
            rd_ptr_n = rd_ptr + CW'(1);
          end else if (is_special) begin
            emit_b   = 8'h7D;
            esc_n    = 1'b1;
          end else begin
            emit_b   = cur_b;
            rd_ptr_n = rd_ptr + CW'(1);
          end
          send_n     = 1'b1;
          byte_n     = emit_b;
          hold_n     = 2'd3;
          checksum_n = checksum + emit_b;
        end
      end
      S_HASH: begin
        if (can_emit) begin
          send_n  = 1'b1;
          byte_n  = 8'h23;
          hold_n  = 2'd3;
          state_n = S_CK_HI;
        end
      end
      S_CK_HI: begin
        if (can_emit) begin
          send_n  = 1'b1;
          byte_n  = hex_ascii(checksum[7:4]);
          hold_n  = 2'd3;
          state_n = S_CK_LO;
        end
      end
      S_CK_LO: begin
        if (can_emit) begin
          send_n  = 1'b1;
          byte_n  = hex_ascii(checksum[3:0]);
          hold_n  = 2'd3;
          state_n = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (ack_plus) begin
          done_n  = 1'b1;
          count_n = '0;
          retry_n = '0;
          state_n = S_IDLE;
        end else if (ack_minus || timed_out) begin
          if (retry < MAX_RETRY_C) begin
            retry_n = retry + RW'(1);
            state_n = S_SOF;
          end else begin
            fail_n  = 1'b1;
            count_n = '0;
            retry_n = '0;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.pl_ready_o = (state == S_IDLE) && (count < DEPTH_C);
  assign bus.tx_send_o  = send_q;
  assign bus.tx_byte_o  = byte_q;
  assign bus.busy_o     = (state != S_IDLE);
  assign bus.done_o     = done_q;
  assign bus.fail_o     = fail_q;
  assign bus.dbg_state  = state;
endmodule

// File: tb/tb_gdb_rsp_tx_framer.sv
// Bench for gdb_rsp_tx_framer: table of payloads with hand-computed checksums,
// plus sequences for retry, timeout, tx stall and mid-frame reset.
module tb_gdb_rsp_tx_framer;
  localparam int DL = 3;
  localparam int MR = 3;
  localparam int TO = 50;
  localparam int LIMIT = 5000;
  localparam logic [2:0] S_IDLE = 3'd0, S_SOF = 3'd1, S_DATA = 3'd2, S_WAIT = 3'd6;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gdb_rsp_tx_framer_if bus();

  gdb_rsp_tx_framer #(.DEPTH_LOG2(DL), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0][7:0] pl;
    logic [3:0]      len;
    logic [1:0]      mode;   // 0: separate commit, 1: commit with last byte, 2: implicit (full)
    logic [7:0]      ck;
    logic            noise;  // send an unrelated ack byte before '+'
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_q [$];
  int checks = 0, errors = 0;
  int done_cnt = 0, fail_cnt = 0, send_cnt = 0, sof_cnt = 0, uart_busy = 0;
  logic stall = 1'b0;
  logic prev_rdy = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    string hx = "0123456789abcdef";
    return hx[n];
  endfunction

  function automatic vec_t mk(input logic [63:0] pl, input int len, input int mode,
                              input logic [7:0] ck, input logic noise);
    vec_t v;
    v.pl = pl; v.len = 4'(len); v.mode = 2'(mode); v.ck = ck; v.noise = noise;
    return v;
  endfunction

  task automatic push_frame(input int idx);
    logic [7:0] b;
    exp_q.push_back(8'h24);
    for (int j = 0; j < int'(vecs[idx].len); j++) begin
      b = vecs[idx].pl[j];
      if (b == 8'h23 || b == 8'h24 || b == 8'h7D || b == 8'h2A) begin
        exp_q.push_back(8'h7D);
        exp_q.push_back(b ^ 8'h20);
      end else begin
        exp_q.push_back(b);
      end
    end
    exp_q.push_back(8'h23);
    exp_q.push_back(hex_ch(vecs[idx].ck[7:4]));
    exp_q.push_back(hex_ch(vecs[idx].ck[3:0]));
  endtask

  // driver tasks
  task automatic load(input int idx);
    int n;
    n = int'(vecs[idx].len);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      bus.pl_valid_i  = 1'b1;
      bus.pl_byte_i   = vecs[idx].pl[j];
      bus.pl_commit_i = (vecs[idx].mode == 2'd1) && (j == n - 1);
    end
    @(posedge clk); #1;
    bus.pl_valid_i  = 1'b0;
    bus.pl_commit_i = 1'b0;
    if (vecs[idx].mode == 2'd0) begin
      bus.pl_commit_i = 1'b1;
      @(posedge clk); #1;
      bus.pl_commit_i = 1'b0;
    end
  endtask

  task automatic send_ack(input logic [7:0] b);
    @(posedge clk); #1;
    bus.ack_valid_i = 1'b1;
    bus.ack_byte_i  = b;
    @(posedge clk); #1;
    bus.ack_valid_i = 1'b0;
    bus.ack_byte_i  = 8'h00;
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n = 0;
    @(negedge clk);
    while (bus.dbg_state !== s && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({"reach_", nm}, 32'(n < LIMIT), 32'd1);
  endtask

  task automatic wait_sends(input int target);
    int n = 0;
    while (send_cnt < target && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("reach_sends", 32'(n < LIMIT), 32'd1);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input int idx);
    int d0, f0;
    d0 = done_cnt; f0 = fail_cnt;
    push_frame(idx);
    load(idx);
    wait_state(S_WAIT, "wait_ack");
    settle();
    check($sformatf("v%0d_frame_drained", idx), 32'(exp_q.size()), 32'd0);
    if (vecs[idx].noise) begin
      send_ack(8'h41);
      settle();
      check($sformatf("v%0d_noise_ignored", idx), 32'(bus.dbg_state), 32'(S_WAIT));
    end
    send_ack(8'h2B);
    wait_state(S_IDLE, "idle");
    settle();
    check($sformatf("v%0d_done", idx), 32'(done_cnt - d0), 32'd1);
    check($sformatf("v%0d_nofail", idx), 32'(fail_cnt - f0), 32'd0);
    check($sformatf("v%0d_busy", idx), 32'(bus.busy_o), 32'd0);
    check($sformatf("v%0d_ready", idx), 32'(bus.pl_ready_o), 32'd1);
  endtask

  // UART model: busy for a random number of cycles after each strobe
  initial forever begin
    @(negedge clk);
    if (bus.tx_send_o === 1'b1) uart_busy = $urandom_range(0, 4);
    else if (uart_busy > 0) uart_busy--;
    @(posedge clk); #1;
    bus.tx_ready_i = !(stall || uart_busy != 0);
  end

  // scoreboard / monitor
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (bus.tx_send_o === 1'b1) begin
      send_cnt++;
      if (bus.tx_byte_o == 8'h24) sof_cnt++;
      check("send_after_ready", 32'(prev_rdy), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_send", 32'(bus.tx_byte_o), 32'h100);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", 32'(bus.tx_byte_o), 32'(e));
      end
    end
    if (bus.done_o === 1'b1) done_cnt++;
    if (bus.fail_o === 1'b1) fail_cnt++;
    if (bus.done_o === 1'b1 || bus.fail_o === 1'b1)
      check("status_pulse_excl", {30'd0, bus.tx_send_o, bus.done_o & bus.fail_o}, 32'd0);
    prev_rdy = bus.tx_ready_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0, s0, sof0;
    time t0, t1;
    vecs[0] = mk(64'h4B4F,             2, 0, 8'h9A, 1'b0);
    vecs[1] = mk(64'h0,                0, 0, 8'h00, 1'b1);
    vecs[2] = mk(64'h4123,             2, 1, 8'hC1, 1'b0);
    vecs[3] = mk(64'h2A7D24,           3, 0, 8'hE2, 1'b0);
    vecs[4] = mk(64'h7EFF00,           3, 1, 8'h7D, 1'b1);
    vecs[5] = mk(64'h0807060504030201, 8, 2, 8'h24, 1'b0);

    bus.pl_byte_i = 8'h00; bus.pl_valid_i = 1'b0; bus.pl_commit_i = 1'b0;
    bus.tx_ready_i = 1'b1; bus.ack_byte_i = 8'h00; bus.ack_valid_i = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_state",    32'(bus.dbg_state),  32'(S_IDLE));
    check("rst_pl_ready", 32'(bus.pl_ready_o), 32'd1);
    check("rst_tx_send",  32'(bus.tx_send_o),  32'd0);
    check("rst_tx_byte",  32'(bus.tx_byte_o),  32'd0);
    check("rst_busy",     32'(bus.busy_o),     32'd0);
    check("rst_done",     32'(bus.done_o),     32'd0);
    check("rst_fail",     32'(bus.fail_o),     32'd0);

    // an ack while idle does nothing
    send_ack(8'h2B);
    settle();
    check("idle_ack_no_done", 32'(done_cnt), 32'd0);
    check("idle_ack_no_busy", 32'(bus.busy_o), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // '-' four times: original plus three retries, then fail
    d0 = done_cnt; f0 = fail_cnt; sof0 = sof_cnt;
    for (int k = 0; k < 4; k++) push_frame(0);
    load(0);
    for (int k = 0; k < 4; k++) begin
      wait_state(S_WAIT, "nak_wait");
      send_ack(8'h2D);
    end
    settle();
    check("nak4_frames", 32'(sof_cnt - sof0), 32'd4);
    check("nak4_fail",   32'(fail_cnt - f0),  32'd1);
    check("nak4_nodone", 32'(done_cnt - d0),  32'd0);
    check("nak4_queue",  32'(exp_q.size()),   32'd0);
    check("nak4_busy",   32'(bus.busy_o),     32'd0);

    // '-' then '+'
    d0 = done_cnt; f0 = fail_cnt; sof0 = sof_cnt;
    push_frame(0); push_frame(0);
    load(0);
    wait_state(S_WAIT, "nak_wait");
    send_ack(8'h2D);
    wait_state(S_WAIT, "nak_wait2");
    send_ack(8'h2B);
    wait_state(S_IDLE, "idle");
    settle();
    check("nakack_frames", 32'(sof_cnt - sof0), 32'd2);
    check("nakack_done",   32'(done_cnt - d0),  32'd1);
    check("nakack_nofail", 32'(fail_cnt - f0),  32'd0);

    // timeout: SOF re-entered TO cycles after WAIT_ACK entry
    d0 = done_cnt;
    push_frame(0); push_frame(0);
    load(0);
    wait_state(S_WAIT, "to_wait");
    t0 = $time;
    wait_state(S_SOF, "to_sof");
    t1 = $time;
    check("timeout_cycles", 32'((t1 - t0) / 10), 32'(TO));
    wait_state(S_WAIT, "to_wait2");
    send_ack(8'h2B);
    wait_state(S_IDLE, "idle");
    settle();
    check("timeout_done",  32'(done_cnt - d0), 32'd1);
    check("timeout_queue", 32'(exp_q.size()),  32'd0);

    // tx_ready_i held low for 100 cycles mid-DATA
    d0 = done_cnt;
    push_frame(5);
    s0 = send_cnt;
    load(5);
    wait_sends(s0 + 3);
    check("stall_in_data", 32'(bus.dbg_state), 32'(S_DATA));
    stall = 1'b1;
    settle();
    s0 = send_cnt;
    repeat (98) @(negedge clk);
    check("stall_no_send", 32'(send_cnt - s0), 32'd0);
    stall = 1'b0;
    wait_state(S_WAIT, "stall_wait");
    send_ack(8'h2B);
    wait_state(S_IDLE, "idle");
    settle();
    check("stall_done",  32'(done_cnt - d0), 32'd1);
    check("stall_queue", 32'(exp_q.size()),  32'd0);

    // reset during DATA abandons the frame silently
    d0 = done_cnt; f0 = fail_cnt;
    push_frame(5);
    s0 = send_cnt;
    load(5);
    wait_sends(s0 + 3);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mrst_state",    32'(bus.dbg_state),  32'(S_IDLE));
    check("mrst_pl_ready", 32'(bus.pl_ready_o), 32'd1);
    check("mrst_tx_send",  32'(bus.tx_send_o),  32'd0);
    check("mrst_busy",     32'(bus.busy_o),     32'd0);
    repeat (5) @(negedge clk);
    check("mrst_no_send",  32'(send_cnt - s0) <= 32'd4 ? 32'd1 : 32'd0, 32'd1);
    check("mrst_no_done",  32'(done_cnt - d0), 32'd0);
    check("mrst_no_fail",  32'(fail_cnt - f0), 32'd0);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
